branch_predict_table: RTL

Owns the gshare pattern history table (PHT), the branch target buffer (BTB) and the global branch history register (GHR). Fetch reads predictions from it, and the execute-stage branch resolver writes training data into it. Lookups use a synchronous read: the address is presented as next-PC and the result arrives aligned with PC, the same timing as instruction memory. Also provides GHR checkpoint and restore for misprediction recovery.

---
 rtl/branch_predict_table_pkg.sv | 28 ++
 rtl/branch_predict_table_sat.sv | 19 +
 rtl/branch_predict_table.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_table_pkg.sv
// Shared types for the gshare predictor: default table geometry, counter and
// history typedefs, the BTB entry layout and the table controller state.
package branch_predict_table_pkg;

  localparam int BP_ADDR_W    = 32;
  localparam int BP_PHT_IDX_W = 10;
  localparam int BP_GHR_W     = 10;
  localparam int BP_BTB_IDX_W = 6;
  localparam int BP_BTB_TAG_W = BP_ADDR_W - BP_BTB_IDX_W - 2;

  typedef logic [1:0]              PhtCounter;
  typedef logic [BP_GHR_W-1:0]     GlobalHistory;
  typedef logic [BP_PHT_IDX_W-1:0] PhtIndex;

  typedef struct packed {
    logic                    valid;
    logic [BP_BTB_TAG_W-1:0] tag;
    logic [BP_ADDR_W-1:0]    target;
  } BtbEntry;

  typedef enum logic {
    BPRED_INIT = 1'b0,
    BPRED_RUN  = 1'b1
  } BpredState;

  localparam PhtCounter PHT_WEAK_NT = 2'b01;

endpackage

// File: rtl/branch_predict_table_sat.sv
// Two-bit saturating counter next-value: shared by training and lookup bypass.
module sat_counter_2b
  import branch_predict_table_pkg::*;
(
  input  PhtCounter cnt,
  input  logic      taken,
  output PhtCounter nxt
);

  always_comb begin
    nxt = cnt;
    if (taken && (cnt != 2'b11)) begin
      nxt = cnt + 2'd1;
    end else if (!taken && (cnt != 2'b00)) begin
      nxt = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_table.sv
// gshare PHT + direct-mapped BTB + global history with one-cycle synchronous lookup.
// Optional BPRED_WRITE_BYPASS_EN forwards same-cycle training/history into the lookup.
module branch_predict_table
  import branch_predict_table_pkg::*;
#(
  parameter int ADDR_W    = BP_ADDR_W,
  parameter int PHT_IDX_W = BP_PHT_IDX_W,
  parameter int GHR_W     = BP_GHR_W,
  parameter int BTB_IDX_W = BP_BTB_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              lookupEn,
  input  logic [ADDR_W-1:0] lookupPc,
  output logic              predTaken,
  output logic              btbHit,
  output logic [ADDR_W-1:0] btbTarget,
  output logic [GHR_W-1:0]  ghrOut,
  input  logic              specValid,
  input  logic              specTaken,
  input  logic              updValid,
  input  logic [ADDR_W-1:0] updPc,
  input  logic              updTaken,
  input  logic [ADDR_W-1:0] updTarget,
  input  logic [GHR_W-1:0]  updGhr,
  input  logic              updMispredict
);

  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = ADDR_W - BTB_IDX_W - 2;

  typedef logic [PHT_IDX_W-1:0] pht_idx_t;
  typedef logic [BTB_IDX_W-1:0] btb_idx_t;
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  target_tag;
    logic [ADDR_W-1:0] target;
  } btb_entry_t;

  PhtCounter  pht [PHT_N];
  btb_entry_t btb [BTB_N];

  BpredState  state_q;
  BpredState  state_d;
  pht_idx_t   init_idx;
  logic       run;

  logic [GHR_W-1:0] ghr;
  logic [GHR_W-1:0] ghr_next;

  logic       upd_fire;
  pht_idx_t   upd_pht_idx;
  btb_idx_t   upd_btb_idx;
  PhtCounter  upd_cnt;
  PhtCounter  upd_cnt_next;
  btb_entry_t upd_entry;

  logic [GHR_W-1:0] lk_ghr;
  pht_idx_t   lk_pht_idx;
  btb_idx_t   lk_btb_idx;
  PhtCounter  lk_cnt;
  btb_entry_t lk_entry;
  logic       lk_hit;

  logic              pred_taken_p1;
  logic              btb_hit_p1;
  logic [ADDR_W-1:0] btb_target_p1;
  logic [GHR_W-1:0]  ghr_out_p1;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookupPc[1:0], updPc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BPRED_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == BPRED_INIT) && (init_idx == '1)) begin
      state_d = BPRED_RUN;
    end
  end

  always_comb begin
    run   = (state_q == BPRED_RUN);
    ready = run;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx <= '0;
    end else if (state_q == BPRED_INIT) begin
      init_idx <= init_idx + 1'b1;
    end
  end

  // Training request decode; PHT index uses the history the branch was predicted with
  assign upd_fire    = run && updValid;
  assign upd_pht_idx = updPc[PHT_IDX_W+1:2] ^ pht_idx_t'(updGhr);
  assign upd_btb_idx = updPc[BTB_IDX_W+1:2];
  assign upd_cnt     = pht[upd_pht_idx];
  assign upd_entry   = '{valid: 1'b1, target_tag: updPc[ADDR_W-1:BTB_IDX_W+2], target: updTarget};

  sat_counter_2b u_sat (
    .cnt   (upd_cnt),
    .taken (updTaken),
    .nxt   (upd_cnt_next)
  );

  // Misprediction repair outranks speculative shifting
  always_comb begin
    ghr_next = ghr;
    if (upd_fire && updMispredict) begin
      ghr_next = {updGhr[GHR_W-2:0], updTaken};
    end else if (run && specValid) begin
      ghr_next = {ghr[GHR_W-2:0], specTaken};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else begin
      ghr <= ghr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == BPRED_INIT) begin
        pht[init_idx] <= PHT_WEAK_NT;
        if ((init_idx >> BTB_IDX_W) == '0) begin
          btb[init_idx[BTB_IDX_W-1:0]].valid <= 1'b0;
        end
      end else if (updValid) begin
        pht[upd_pht_idx] <= upd_cnt_next;
        if (updTaken) begin
          btb[upd_btb_idx] <= upd_entry;
        end
      end
    end
  end

`ifdef BPRED_WRITE_BYPASS_EN
  assign lk_ghr = ghr_next;
`else
  assign lk_ghr = ghr;
`endif

  assign lk_pht_idx = lookupPc[PHT_IDX_W+1:2] ^ pht_idx_t'(lk_ghr);
  assign lk_btb_idx = lookupPc[BTB_IDX_W+1:2];

  always_comb begin
    lk_cnt   = pht[lk_pht_idx];
    lk_entry = btb[lk_btb_idx];
`ifdef BPRED_WRITE_BYPASS_EN
    if (upd_fire && (upd_pht_idx == lk_pht_idx)) begin
      lk_cnt = upd_cnt_next;
    end
    if (upd_fire && updTaken && (upd_btb_idx == lk_btb_idx)) begin
      lk_entry = upd_entry;
    end
`endif
    lk_hit = lk_entry.valid && (lk_entry.target_tag == lookupPc[ADDR_W-1:BTB_IDX_W+2]);
  end

  // Stage p1: registered prediction, aligned with the fetch PC
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      pred_taken_p1 <= 1'b0;
      btb_hit_p1    <= 1'b0;
      btb_target_p1 <= '0;
      ghr_out_p1    <= '0;
    end else if (lookupEn) begin
      pred_taken_p1 <= lk_cnt[1];
      btb_hit_p1    <= lk_hit;
      btb_target_p1 <= lk_hit ? lk_entry.target : '0;
      ghr_out_p1    <= lk_ghr;
    end
  end

  assign predTaken = pred_taken_p1;
  assign btbHit    = btb_hit_p1;
  assign btbTarget = btb_target_p1;
  assign ghrOut    = ghr_out_p1;

endmodule
